// File: rtl/cpu_reg_pkg.sv
// Shared types and helpers for the CPU pointer-style registers.
package cpu_reg_pkg;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_LOAD,
        OP_INC,
        OP_DEC
    } reg_op_t;

    // A single input still needs a 1-bit select so the select port never collapses to zero width.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_priority_mux.sv
// Highest-index-wins priority encoder and word mux over packed bus inputs.
module bus_priority_mux
    import cpu_reg_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned INPUT_COUNT = 2
) (
    input  logic [WIDTH*INPUT_COUNT-1:0] bus_inputs,
    input  logic [INPUT_COUNT-1:0]       read_enable,
    output logic [WIDTH-1:0]             sel_word,
    output logic                         any_valid,
    output logic                         multi_hot
);

    localparam int unsigned SEL_W = sel_width(INPUT_COUNT);

    logic [SEL_W-1:0] sel;

    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < INPUT_COUNT; i++) begin
            if (read_enable[i]) begin
                sel = SEL_W'(i);
            end
        end
    end

    always_comb begin
        sel_word = '0;
        for (int unsigned i = 0; i < INPUT_COUNT; i++) begin
            if (SEL_W'(i) == sel) begin
                sel_word = bus_inputs[i*WIDTH +: WIDTH];
            end
        end
    end

    assign any_valid = |read_enable;
    assign multi_hot = ($countones(read_enable) > 1);

endmodule

// File: rtl/counting_bus_register.sv
// Bus register with priority load, wrapping inc/dec, carry/zero flags and sticky conflict detection.
module counting_bus_register
    import cpu_reg_pkg::*;
#(
    parameter int unsigned      WIDTH         = 8,
    parameter int unsigned      INPUT_COUNT   = 2,
    parameter int unsigned      OUTPUT_COUNT  = 1,
    parameter logic [WIDTH-1:0] DEFAULT_VALUE = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH*INPUT_COUNT-1:0]  busInputs,
    input  logic [INPUT_COUNT-1:0]        busReadEnable,
    input  logic                          incEnable,
    input  logic                          decEnable,
    input  logic [OUTPUT_COUNT-1:0]       busWriteEnable,
    output logic [WIDTH*OUTPUT_COUNT-1:0] busOutputs,
    output logic [WIDTH-1:0]              value,
    output logic                          carry,
    output logic                          zero,
    output logic                          conflict,
    input  logic                          clearConflict
);

    logic [WIDTH-1:0] value_q, value_d;
    logic             carry_q, carry_d;
    logic             conflict_q, conflict_d;

    logic [WIDTH-1:0] load_word;
    logic             load_valid;
    logic             load_multi;
    reg_op_t          op;
    logic [WIDTH:0]   inc_sum;
    logic [WIDTH:0]   dec_diff;

    bus_priority_mux #(
        .WIDTH       (WIDTH),
        .INPUT_COUNT (INPUT_COUNT)
    ) u_mux (
        .bus_inputs  (busInputs),
        .read_enable (busReadEnable),
        .sel_word    (load_word),
        .any_valid   (load_valid),
        .multi_hot   (load_multi)
    );

    always_comb begin
        op = OP_HOLD;
        if (load_valid) begin
            op = OP_LOAD;
        end else if (incEnable && !decEnable) begin
            op = OP_INC;
        end else if (decEnable && !incEnable) begin
            op = OP_DEC;
        end
    end

    // The extra top bit carries out of an increment or borrows out of a decrement.
    assign inc_sum  = {1'b0, value_q} + (WIDTH+1)'(1);
    assign dec_diff = {1'b0, value_q} - (WIDTH+1)'(1);

    always_comb begin
        value_d    = value_q;
        carry_d    = carry_q;
        conflict_d = conflict_q;

        unique case (op)
            OP_LOAD: value_d = load_word;
            OP_INC: begin
                value_d = inc_sum[WIDTH-1:0];
                carry_d = inc_sum[WIDTH];
            end
            OP_DEC: begin
                value_d = dec_diff[WIDTH-1:0];
                carry_d = dec_diff[WIDTH];
            end
            default: ;
        endcase

        // Set wins over clear in the same cycle.
        if (clearConflict) begin
            conflict_d = 1'b0;
        end
        if (load_multi) begin
            conflict_d = 1'b1;
        end

        if (rst) begin
            value_d    = DEFAULT_VALUE;
            carry_d    = 1'b0;
            conflict_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        value_q    <= value_d;
        carry_q    <= carry_d;
        conflict_q <= conflict_d;
    end

    always_comb begin
        busOutputs = '0;
        for (int unsigned j = 0; j < OUTPUT_COUNT; j++) begin
            if (busWriteEnable[j]) begin
                busOutputs[j*WIDTH +: WIDTH] = value_q;
            end
        end
    end

    assign value    = value_q;
    assign carry    = carry_q;
    assign zero     = (value_q == '0);
    assign conflict = conflict_q;

endmodule

// File: tb/tb_counting_bus_register.sv
// Scoreboard bench for counting_bus_register (3-input/2-output and 1-input variants).
module tb_counting_bus_register;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [23:0] bus_in;
    logic [2:0]  re;
    logic        inc, dec, clr;
    logic [1:0]  we;
    logic [15:0] bus_out;
    logic [7:0]  value;
    logic        carry, zero, conflict;

    logic [7:0]  a_in;
    logic        a_re, a_inc, a_dec, a_clr, a_we;
    logic [7:0]  a_out, a_value;
    logic        a_carry, a_zero, a_conflict;

    counting_bus_register #(
        .WIDTH         (8),
        .INPUT_COUNT   (3),
        .OUTPUT_COUNT  (2),
        .DEFAULT_VALUE (8'hFD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .busInputs      (bus_in),
        .busReadEnable  (re),
        .incEnable      (inc),
        .decEnable      (dec),
        .busWriteEnable (we),
        .busOutputs     (bus_out),
        .value          (value),
        .carry          (carry),
        .zero           (zero),
        .conflict       (conflict),
        .clearConflict  (clr)
    );

    counting_bus_register #(
        .WIDTH         (8),
        .INPUT_COUNT   (1),
        .OUTPUT_COUNT  (1),
        .DEFAULT_VALUE (8'h00)
    ) dut1 (
        .clk            (clk),
        .rst            (rst),
        .busInputs      (a_in),
        .busReadEnable  (a_re),
        .incEnable      (a_inc),
        .decEnable      (a_dec),
        .busWriteEnable (a_we),
        .busOutputs     (a_out),
        .value          (a_value),
        .carry          (a_carry),
        .zero           (a_zero),
        .conflict       (a_conflict),
        .clearConflict  (a_clr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [7:0] v;
        logic       c;
        logic       cf;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_v;
    logic       m_c, m_cf;

    // Advance the reference model on the current inputs, push, clock, then pop and compare.
    task automatic step();
        exp_t e;
        if (rst) begin
            m_v  = 8'hFD;
            m_c  = 1'b0;
            m_cf = 1'b0;
        end else begin
            if (re != 3'b000) begin
                if (re[2])      m_v = bus_in[23:16];
                else if (re[1]) m_v = bus_in[15:8];
                else            m_v = bus_in[7:0];
            end else if (inc && !dec) begin
                m_c = (m_v == 8'hFF);
                m_v = m_v + 8'd1;
            end else if (dec && !inc) begin
                m_c = (m_v == 8'h00);
                m_v = m_v - 8'd1;
            end
            if ($countones(re) > 1) m_cf = 1'b1;
            else if (clr)           m_cf = 1'b0;
        end
        e.v = m_v; e.c = m_c; e.cf = m_cf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("value", value, e.v);
        check("carry", carry, e.c);
        check("conflict", conflict, e.cf);
        check("zero", zero, e.v == 8'h00);
        check("bus_out", bus_out, {(we[1] ? e.v : 8'h00), (we[0] ? e.v : 8'h00)});
    endtask

    task automatic idle();
        re = 3'b000; inc = 1'b0; dec = 1'b0; clr = 1'b0;
    endtask

    task automatic load0(input logic [7:0] d);
        bus_in[7:0] = d;
        re = 3'b001;
        step();
        idle();
    endtask

    initial begin
        rst = 1'b1; bus_in = '0; we = 2'b01; idle();
        a_in = '0; a_re = 1'b0; a_inc = 1'b0; a_dec = 1'b0; a_clr = 1'b0; a_we = 1'b1;

        step();
        step();
        rst = 1'b0;
        step();
        check("reset_value", value, 8'hFD);
        check("reset_carry", carry, 1'b0);
        check("reset_conflict", conflict, 1'b0);
        check("dut1_reset_value", a_value, 8'h00);
        we = 2'b01; #1;
        check("gate_01", bus_out, 16'h00FD);
        we = 2'b00; #1;
        check("gate_00", bus_out, 16'h0000);
        we = 2'b11;

        bus_in = {8'h33, 8'h22, 8'h11};
        re = 3'b110;
        step();
        idle();
        check("prio_value", value, 8'h33);
        check("prio_conflict", conflict, 1'b1);
        clr = 1'b1;
        step();
        idle();
        check("clear_conflict", conflict, 1'b0);

        load0(8'hFE);
        inc = 1'b1;
        step();
        check("inc_ff", value, 8'hFF);
        check("inc_ff_carry", carry, 1'b0);
        step();
        check("inc_wrap", value, 8'h00);
        check("inc_wrap_carry", carry, 1'b1);
        check("inc_wrap_zero", zero, 1'b1);
        inc = 1'b0; dec = 1'b1;
        step();
        check("dec_wrap", value, 8'hFF);
        check("dec_wrap_borrow", carry, 1'b1);
        step();
        check("dec_fe", value, 8'hFE);
        check("dec_fe_borrow", carry, 1'b0);
        idle();

        load0(8'h40);
        inc = 1'b1; dec = 1'b1;
        step();
        idle();
        check("incdec_hold", value, 8'h40);
        check("incdec_carry", carry, 1'b0);

        bus_in = {8'h33, 8'h22, 8'h11};
        re = 3'b001; inc = 1'b1;
        step();
        idle();
        check("load_beats_inc", value, 8'h11);

        re = 3'b011;
        step();
        re = 3'b011; clr = 1'b1;
        step();
        idle();
        check("set_beats_clear", conflict, 1'b1);
        clr = 1'b1;
        step();
        idle();

        load0(8'h7F);
        inc = 1'b1; rst = 1'b1;
        step();
        check("midrst_value", value, 8'hFD);
        check("midrst_carry", carry, 1'b0);
        rst = 1'b0; inc = 1'b0;
        step();
        check("release_no_inc", value, 8'hFD);

        for (int k = 0; k < 200; k++) begin
            bus_in = {$urandom()} [23:0];
            re  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            inc = 1'($urandom_range(0, 1));
            dec = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 3) == 0);
            we  = 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 49) == 0);
            step();
        end
        rst = 1'b0; idle();

        a_in = 8'hA5; a_re = 1'b1;
        @(posedge clk); #1;
        check("single_load", a_value, 8'hA5);
        check("single_out", a_out, 8'hA5);
        a_re = 1'b0; a_inc = 1'b1;
        @(posedge clk); #1;
        check("single_inc", a_value, 8'hA6);
        check("single_carry", a_carry, 1'b0);
        check("single_conflict", a_conflict, 1'b0);
        a_inc = 1'b0;

        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
